// File: rtl/otter_pkg.sv
// Shared OTTER definitions used by the memory port arbiter.
package otter_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        BUSY_I = 2'd1,
        BUSY_D = 2'd2,
        RESP   = 2'd3
    } arb_state_t;

    localparam logic [1:0] MEM_SIZE_BYTE = 2'd0;
    localparam logic [1:0] MEM_SIZE_HALF = 2'd1;
    localparam logic [1:0] MEM_SIZE_WORD = 2'd2;

endpackage

// File: rtl/mem_port_arbiter_if.sv
// Bundle of the fetch, data and memory-side signals around the arbiter.
// slave is the arbiter's view; master is the pipeline/memory view.
interface mem_port_arbiter_if;

    logic        if_req;
    logic [31:0] if_addr;
    logic        if_ack;
    logic [31:0] if_rdata;

    logic        d_req;
    logic        d_we;
    logic [31:0] d_addr;
    logic [31:0] d_wdata;
    logic [1:0]  d_size;
    logic        d_sign;
    logic        d_ack;
    logic [31:0] d_rdata;

    logic        m_req;
    logic        m_we;
    logic [31:0] m_addr;
    logic [31:0] m_wdata;
    logic [1:0]  m_size;
    logic        m_sign;
    logic        m_ready;
    logic [31:0] m_rdata;

    logic        stall_if;
    logic        stall_mem;

    modport slave (
        input  if_req, if_addr, d_req, d_we, d_addr, d_wdata, d_size, d_sign,
               m_ready, m_rdata,
        output if_ack, if_rdata, d_ack, d_rdata,
               m_req, m_we, m_addr, m_wdata, m_size, m_sign,
               stall_if, stall_mem
    );

    modport master (
        output if_req, if_addr, d_req, d_we, d_addr, d_wdata, d_size, d_sign,
               m_ready, m_rdata,
        input  if_ack, if_rdata, d_ack, d_rdata,
               m_req, m_we, m_addr, m_wdata, m_size, m_sign,
               stall_if, stall_mem
    );

endinterface

// File: rtl/starve_counter.sv
// Saturating counter of consecutive data grants taken while fetch waits.
// sat tells the arbiter that fetch must win the next contested grant.
module starve_counter #(
    parameter int CNT_W      = 3,
    parameter int STARVE_MAX = 4
) (
    input  logic CLK,
    input  logic RST,
    input  logic inc,
    input  logic clr,
    output logic sat
);

    localparam logic [CNT_W-1:0] MAX_C = CNT_W'(STARVE_MAX);

    logic [CNT_W-1:0] cnt_r;

    // Count up on inc, hold at MAX_C, clear has priority over inc.
    always_ff @(posedge CLK) begin
        if (RST) begin
            cnt_r <= '0;
        end else if (clr) begin
            cnt_r <= '0;
        end else if (inc && (cnt_r != MAX_C)) begin
            cnt_r <= cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
        end else begin
            cnt_r <= cnt_r;
        end
    end

    assign sat = (cnt_r == MAX_C);

endmodule

// File: rtl/mem_port_arbiter.sv
// Single-outstanding arbiter sharing one memory/IO bus between the fetch
// stage and the memory stage. Data wins contested grants unless fetch has
// already been passed over STARVE_MAX times in a row.
module mem_port_arbiter
    import otter_pkg::*;
#(
    parameter int STARVE_MAX = 4,
    parameter int CNT_W      = 3
) (
    input  logic              CLK,
    input  logic              RST,
    mem_port_arbiter_if.slave bus
);

    arb_state_t  state_r;
    logic        if_ack_r;
    logic        d_ack_r;
    logic [31:0] if_rdata_r;
    logic [31:0] d_rdata_r;
    logic        m_req_r;
    logic        m_we_r;
    logic [31:0] m_addr_r;
    logic [31:0] m_wdata_r;
    logic [1:0]  m_size_r;
    logic        m_sign_r;

    logic        grant_d_s;
    logic        grant_i_s;
    logic        starve_inc_s;
    logic        starve_clr_s;
    logic        starve_sat_s;

    // Decide which requester (if any) is granted on this edge; only in IDLE.
    always_comb begin
        grant_d_s = 1'b0;
        grant_i_s = 1'b0;
        if (state_r == IDLE) begin
            if (bus.d_req && !(bus.if_req && starve_sat_s)) begin
                grant_d_s = 1'b1;
            end else if (bus.if_req) begin
                grant_i_s = 1'b1;
            end else begin
                grant_d_s = 1'b0;
                grant_i_s = 1'b0;
            end
        end else begin
            grant_d_s = 1'b0;
            grant_i_s = 1'b0;
        end
    end

    assign starve_inc_s = grant_d_s & bus.if_req;
    assign starve_clr_s = grant_i_s | (grant_d_s & ~bus.if_req);

    starve_counter #(
        .CNT_W      (CNT_W),
        .STARVE_MAX (STARVE_MAX)
    ) u_starve (
        .CLK (CLK),
        .RST (RST),
        .inc (starve_inc_s),
        .clr (starve_clr_s),
        .sat (starve_sat_s)
    );

    // Transaction FSM: capture request on grant, hold bus until m_ready,
    // then pulse the owner's ack for one cycle.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_r    <= IDLE;
            if_ack_r   <= 1'b0;
            d_ack_r    <= 1'b0;
            if_rdata_r <= 32'd0;
            d_rdata_r  <= 32'd0;
            m_req_r    <= 1'b0;
            m_we_r     <= 1'b0;
            m_addr_r   <= 32'd0;
            m_wdata_r  <= 32'd0;
            m_size_r   <= 2'd0;
            m_sign_r   <= 1'b0;
        end else begin
            case (state_r)
                IDLE: begin
                    if_ack_r <= 1'b0;
                    d_ack_r  <= 1'b0;
                    if (grant_d_s) begin
                        m_req_r   <= 1'b1;
                        m_we_r    <= bus.d_we;
                        m_addr_r  <= bus.d_addr;
                        m_wdata_r <= bus.d_wdata;
                        m_size_r  <= bus.d_size;
                        m_sign_r  <= bus.d_sign;
                        state_r   <= BUSY_D;
                    end else if (grant_i_s) begin
                        m_req_r   <= 1'b1;
                        m_we_r    <= 1'b0;
                        m_addr_r  <= bus.if_addr;
                        m_wdata_r <= 32'd0;
                        m_size_r  <= MEM_SIZE_WORD;
                        m_sign_r  <= 1'b0;
                        state_r   <= BUSY_I;
                    end else begin
                        state_r <= IDLE;
                    end
                end
                BUSY_I: begin
                    if (bus.m_ready) begin
                        if_rdata_r <= bus.m_rdata;
                        m_req_r    <= 1'b0;
                        if_ack_r   <= 1'b1;
                        state_r    <= RESP;
                    end else begin
                        state_r <= BUSY_I;
                    end
                end
                BUSY_D: begin
                    if (bus.m_ready) begin
                        // Stores return no data; loads pass memory data as-is.
                        d_rdata_r <= m_we_r ? 32'd0 : bus.m_rdata;
                        m_req_r   <= 1'b0;
                        d_ack_r   <= 1'b1;
                        state_r   <= RESP;
                    end else begin
                        state_r <= BUSY_D;
                    end
                end
                RESP: begin
                    if_ack_r <= 1'b0;
                    d_ack_r  <= 1'b0;
                    state_r  <= IDLE;
                end
                default: begin
                    if_ack_r <= 1'b0;
                    d_ack_r  <= 1'b0;
                    m_req_r  <= 1'b0;
                    state_r  <= IDLE;
                end
            endcase
        end
    end

    assign bus.if_ack    = if_ack_r;
    assign bus.if_rdata  = if_rdata_r;
    assign bus.d_ack     = d_ack_r;
    assign bus.d_rdata   = d_rdata_r;
    assign bus.m_req     = m_req_r;
    assign bus.m_we      = m_we_r;
    assign bus.m_addr    = m_addr_r;
    assign bus.m_wdata   = m_wdata_r;
    assign bus.m_size    = m_size_r;
    assign bus.m_sign    = m_sign_r;
    assign bus.stall_if  = bus.if_req & ~if_ack_r;
    assign bus.stall_mem = bus.d_req & ~d_ack_r;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: directed vector table, corner
// sequences, then random traffic against a transaction-level model.
module tb_mem_port_arbiter;
    import otter_pkg::*;

    localparam int SMAX = 4;

    logic CLK = 1'b0;
    logic RST;
    int   n_checks = 0;
    int   n_fail   = 0;

    mem_port_arbiter_if bus ();

    mem_port_arbiter #(.STARVE_MAX(SMAX), .CNT_W(3)) dut (
        .CLK (CLK),
        .RST (RST),
        .bus (bus)
    );

    // Free-running clock.
    always #5 CLK = ~CLK;

    typedef struct {
        logic        is_d;
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [1:0]  size;
        logic        sign;
        logic [31:0] mrd;
        int          wt;
        logic [31:0] e_addr;
        logic        e_we;
        logic [1:0]  e_size;
        logic        e_sign;
        logic [31:0] e_rdata;
    } vec_t;

    vec_t vt[6];

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic chk32(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic chk1(input string name, input logic act, input logic exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %b expected %b", name, act, exp);
        end
    endtask

    // Apply one isolated request from the table and check every phase.
    task automatic run_vec(input vec_t v, input int idx);
        if (v.is_d) begin
            bus.d_req = 1'b1; bus.d_we = v.we; bus.d_addr = v.addr;
            bus.d_wdata = v.wdata; bus.d_size = v.size; bus.d_sign = v.sign;
        end else begin
            bus.if_req = 1'b1; bus.if_addr = v.addr;
        end
        #1;
        chk1($sformatf("v%0d_stall_c0", idx), v.is_d ? bus.stall_mem : bus.stall_if, 1'b1);
        tick();
        chk1($sformatf("v%0d_m_req", idx), bus.m_req, 1'b1);
        chk32($sformatf("v%0d_m_addr", idx), bus.m_addr, v.e_addr);
        chk1($sformatf("v%0d_m_we", idx), bus.m_we, v.e_we);
        chk32($sformatf("v%0d_m_size", idx), {30'd0, bus.m_size}, {30'd0, v.e_size});
        chk1($sformatf("v%0d_m_sign", idx), bus.m_sign, v.e_sign);
        if (v.e_we) chk32($sformatf("v%0d_m_wdata", idx), bus.m_wdata, v.wdata);
        for (int k = 0; k < v.wt; k++) begin
            tick();
            chk1($sformatf("v%0d_m_req_hold", idx), bus.m_req, 1'b1);
            chk1($sformatf("v%0d_ack_early", idx), bus.if_ack | bus.d_ack, 1'b0);
        end
        bus.m_ready = 1'b1; bus.m_rdata = v.mrd;
        #1;
        chk1($sformatf("v%0d_stall_c1", idx), v.is_d ? bus.stall_mem : bus.stall_if, 1'b1);
        tick();
        bus.m_ready = 1'b0;
        chk1($sformatf("v%0d_if_ack", idx), bus.if_ack, !v.is_d);
        chk1($sformatf("v%0d_d_ack", idx), bus.d_ack, v.is_d);
        chk32($sformatf("v%0d_rdata", idx), v.is_d ? bus.d_rdata : bus.if_rdata, v.e_rdata);
        chk1($sformatf("v%0d_m_req_resp", idx), bus.m_req, 1'b0);
        bus.if_req = 1'b0; bus.d_req = 1'b0;
        tick();
        chk1($sformatf("v%0d_ack_clear", idx), bus.if_ack | bus.d_ack, 1'b0);
    endtask

    // Wait for the next memory request, complete it after wait_n cycles and
    // report which port was acked.
    task automatic serve_one(input int wait_n, input logic [31:0] rd,
                             output logic [7:0] kind, output logic [31:0] ma,
                             output logic mwe, output logic [31:0] mwd,
                             output logic [31:0] ackd);
        int n;
        n = 0; kind = "X"; ma = 32'd0; mwe = 1'b0; mwd = 32'd0; ackd = 32'd0;
        while (!bus.m_req && n < 20) begin
            tick();
            n++;
        end
        if (!bus.m_req) begin
            n_checks++; n_fail++;
            $display("FAIL serve_timeout: got no m_req expected m_req within 20 cycles");
            return;
        end
        ma = bus.m_addr; mwe = bus.m_we; mwd = bus.m_wdata;
        repeat (wait_n) tick();
        bus.m_ready = 1'b1; bus.m_rdata = rd;
        tick();
        bus.m_ready = 1'b0;
        if (bus.if_ack && !bus.d_ack) begin
            kind = "I"; ackd = bus.if_rdata;
        end else if (bus.d_ack && !bus.if_ack) begin
            kind = "D"; ackd = bus.d_rdata;
        end else begin
            kind = "X";
        end
    endtask

    // Random traffic checked against a transaction-level arbitration model.
    task automatic rand_phase(input int ncyc);
        int          ap, mcnt, starve, idle_w;
        logic        pend, ia, da, want_d, e_we, e_sign;
        logic [31:0] e_addr, e_wdata, e_rd;
        logic [1:0]  e_size;
        ap = 0; mcnt = 0; starve = 0; idle_w = 0; pend = 1'b0;
        e_we = 1'b0; e_sign = 1'b0; e_addr = 32'd0; e_wdata = 32'd0; e_rd = 32'd0; e_size = 2'd0;
        for (int c = 0; c < ncyc; c++) begin
            tick();
            ia = bus.if_ack; da = bus.d_ack;
            chk1("r_stall_if", bus.stall_if, bus.if_req & ~ia);
            chk1("r_stall_mem", bus.stall_mem, bus.d_req & ~da);
            if (pend) begin
                chk1("r_if_ack", ia, ap == 1);
                chk1("r_d_ack", da, ap == 2);
                chk1("r_m_req_resp", bus.m_req, 1'b0);
                chk32("r_rdata", (ap == 1) ? bus.if_rdata : bus.d_rdata, e_rd);
                pend = 1'b0; ap = 0;
            end else begin
                chk1("r_if_ack_idle", ia, 1'b0);
                chk1("r_d_ack_idle", da, 1'b0);
                if (ap == 0 && bus.m_req) begin
                    n_checks++;
                    if (!bus.if_req && !bus.d_req) begin
                        n_fail++;
                        $display("FAIL r_grant_noreq: got m_req=1 expected no grant without requests");
                    end
                    want_d = bus.d_req && !(bus.if_req && starve == SMAX);
                    if (want_d) begin
                        e_addr = bus.d_addr; e_we = bus.d_we; e_wdata = bus.d_wdata;
                        e_size = bus.d_size; e_sign = bus.d_sign; ap = 2;
                        starve = bus.if_req ? ((starve < SMAX) ? starve + 1 : SMAX) : 0;
                    end else begin
                        e_addr = bus.if_addr; e_we = 1'b0; e_wdata = 32'd0;
                        e_size = MEM_SIZE_WORD; e_sign = 1'b0; ap = 1; starve = 0;
                    end
                    mcnt = $urandom_range(0, 3);
                    idle_w = 0;
                end else if (ap == 0) begin
                    idle_w = (bus.if_req || bus.d_req) ? idle_w + 1 : 0;
                    n_checks++;
                    if (idle_w > 3) begin
                        n_fail++;
                        $display("FAIL r_grant_wait: got %0d cycles without grant expected <=3", idle_w);
                        idle_w = 0;
                    end
                end
                if (ap != 0) begin
                    chk1("r_m_req", bus.m_req, 1'b1);
                    chk32("r_m_addr", bus.m_addr, e_addr);
                    chk1("r_m_we", bus.m_we, e_we);
                    chk32("r_m_size", {30'd0, bus.m_size}, {30'd0, e_size});
                    chk1("r_m_sign", bus.m_sign, e_sign);
                    if (ap == 2 && e_we) chk32("r_m_wdata", bus.m_wdata, e_wdata);
                end
            end
            bus.m_ready = 1'b0;
            if (ap != 0 && !pend) begin
                if (mcnt == 0) begin
                    bus.m_ready = 1'b1; bus.m_rdata = $urandom; pend = 1'b1;
                    e_rd = (ap == 2 && e_we) ? 32'd0 : bus.m_rdata;
                end else begin
                    mcnt--;
                end
            end else if (ap == 0 && $urandom_range(0, 7) == 0) begin
                bus.m_ready = 1'b1; bus.m_rdata = $urandom;
            end
            if (ia || !bus.if_req) begin
                if ($urandom_range(0, 2) != 0) begin
                    bus.if_req = 1'b1; bus.if_addr = $urandom & 32'hFFFF_FFFC;
                end else begin
                    bus.if_req = 1'b0;
                end
            end
            if (da || !bus.d_req) begin
                if ($urandom_range(0, 2) != 0) begin
                    bus.d_req = 1'b1; bus.d_we = 1'($urandom_range(0, 1));
                    bus.d_addr = $urandom; bus.d_wdata = $urandom;
                    bus.d_size = 2'($urandom_range(0, 2)); bus.d_sign = 1'($urandom_range(0, 1));
                end else begin
                    bus.d_req = 1'b0;
                end
            end else if (ap == 2) begin
                bus.d_addr = $urandom; bus.d_wdata = $urandom;
            end
        end
        bus.if_req = 1'b0; bus.d_req = 1'b0; bus.m_ready = 1'b0;
    endtask

    // Hard time limit so the run always ends.
    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected run to finish");
        $fatal(1, "watchdog");
    end

    // Main test sequence.
    initial begin
        logic [7:0]  kind;
        logic [31:0] ma, mwd, rd;
        logic        mwe;
        string       seq;

        //            is_d  we    addr          wdata         sz    sg    mrd           wt e_addr        e_we  e_sz  e_sg  e_rdata
        vt[0] = '{1'b0, 1'b0, 32'h0000_0100, 32'h0,        2'd0, 1'b1, 32'h0050_0093, 0, 32'h0000_0100, 1'b0, 2'd2, 1'b0, 32'h0050_0093};
        vt[1] = '{1'b1, 1'b0, 32'h0000_2003, 32'h0,        2'd0, 1'b0, 32'hFFFF_FF80, 0, 32'h0000_2003, 1'b0, 2'd0, 1'b0, 32'hFFFF_FF80};
        vt[2] = '{1'b1, 1'b1, 32'h0000_1004, 32'hDEAD_BEEF, 2'd2, 1'b0, 32'h1234_5678, 1, 32'h0000_1004, 1'b1, 2'd2, 1'b0, 32'h0000_0000};
        vt[3] = '{1'b1, 1'b0, 32'h0000_2002, 32'h0,        2'd1, 1'b1, 32'h0000_ABCD, 2, 32'h0000_2002, 1'b0, 2'd1, 1'b1, 32'h0000_ABCD};
        vt[4] = '{1'b0, 1'b0, 32'h0000_0104, 32'h0,        2'd1, 1'b1, 32'hFFC1_0113, 3, 32'h0000_0104, 1'b0, 2'd2, 1'b0, 32'hFFC1_0113};
        vt[5] = '{1'b1, 1'b1, 32'h0000_3001, 32'h0000_00A5, 2'd0, 1'b1, 32'hFFFF_FFFF, 0, 32'h0000_3001, 1'b1, 2'd0, 1'b1, 32'h0000_0000};

        bus.if_req = 1'b0; bus.if_addr = 32'd0;
        bus.d_req = 1'b0; bus.d_we = 1'b0; bus.d_addr = 32'd0; bus.d_wdata = 32'd0;
        bus.d_size = 2'd0; bus.d_sign = 1'b0; bus.m_ready = 1'b0; bus.m_rdata = 32'd0;
        RST = 1'b1;
        repeat (3) tick();

        chk1("rst_m_req", bus.m_req, 1'b0);
        chk1("rst_m_we", bus.m_we, 1'b0);
        chk32("rst_m_addr", bus.m_addr, 32'd0);
        chk32("rst_m_wdata", bus.m_wdata, 32'd0);
        chk32("rst_m_size", {30'd0, bus.m_size}, 32'd0);
        chk1("rst_m_sign", bus.m_sign, 1'b0);
        chk1("rst_acks", bus.if_ack | bus.d_ack, 1'b0);
        chk32("rst_if_rdata", bus.if_rdata, 32'd0);
        chk32("rst_d_rdata", bus.d_rdata, 32'd0);
        chk1("rst_state", dut.state_r == IDLE, 1'b1);
        chk32("rst_starve", {29'd0, dut.u_starve.cnt_r}, 32'd0);
        chk1("rst_stalls", bus.stall_if | bus.stall_mem, 1'b0);
        RST = 1'b0;
        tick();

        for (int i = 0; i < 6; i++) run_vec(vt[i], i);

        // Simultaneous fetch and store: data first, fetch next.
        bus.if_req = 1'b1; bus.if_addr = 32'h0000_0180;
        bus.d_req = 1'b1; bus.d_we = 1'b1; bus.d_addr = 32'h0000_1004;
        bus.d_wdata = 32'hDEAD_BEEF; bus.d_size = 2'd2; bus.d_sign = 1'b0;
        serve_one(0, 32'h1111_2222, kind, ma, mwe, mwd, rd);
        chk32("sim_first_kind", {24'd0, kind}, {24'd0, 8'h44});
        chk32("sim_m_addr", ma, 32'h0000_1004);
        chk1("sim_m_we", mwe, 1'b1);
        chk32("sim_m_wdata", mwd, 32'hDEAD_BEEF);
        chk32("sim_d_rdata", rd, 32'd0);
        bus.d_req = 1'b0;
        serve_one(0, 32'h2222_3333, kind, ma, mwe, mwd, rd);
        chk32("sim_second_kind", {24'd0, kind}, {24'd0, 8'h49});
        chk32("sim_if_addr", ma, 32'h0000_0180);
        chk32("sim_if_rdata", rd, 32'h2222_3333);
        bus.if_req = 1'b0;
        tick();

        // Starvation: both held, fetch must win after SMAX data grants.
        seq = "DDDDIDDDDI";
        bus.if_req = 1'b1; bus.if_addr = 32'h0000_0200;
        bus.d_req = 1'b1; bus.d_we = 1'b0; bus.d_addr = 32'h0000_0400; bus.d_size = 2'd2;
        for (int i = 0; i < 10; i++) begin
            serve_one(i % 2, 32'h0000_0A00 + 32'(i), kind, ma, mwe, mwd, rd);
            chk32($sformatf("starve_order%0d", i), {24'd0, kind}, {24'd0, seq[i]});
            bus.d_addr = bus.d_addr + 32'd4;
        end
        bus.if_req = 1'b0; bus.d_req = 1'b0;
        repeat (2) tick();

        // Wait states with requester address changing after the grant.
        bus.d_req = 1'b1; bus.d_we = 1'b0; bus.d_addr = 32'h0000_3000; bus.d_size = 2'd2; bus.d_sign = 1'b0;
        tick();
        chk32("ws_m_addr_grant", bus.m_addr, 32'h0000_3000);
        for (int k = 0; k < 5; k++) begin
            bus.d_addr = 32'h4444_0000 + 32'(k);
            tick();
            chk1("ws_m_req", bus.m_req, 1'b1);
            chk32("ws_m_addr_hold", bus.m_addr, 32'h0000_3000);
            chk1("ws_stall_mem", bus.stall_mem, 1'b1);
            chk1("ws_no_ack", bus.d_ack, 1'b0);
        end
        bus.m_ready = 1'b1; bus.m_rdata = 32'hCAFE_F00D;
        #1;
        chk1("ws_stall_ready", bus.stall_mem, 1'b1);
        tick();
        bus.m_ready = 1'b0;
        chk1("ws_d_ack", bus.d_ack, 1'b1);
        chk32("ws_d_rdata", bus.d_rdata, 32'hCAFE_F00D);
        chk1("ws_stall_ack", bus.stall_mem, 1'b0);
        bus.d_req = 1'b0;
        tick();
        chk1("ws_ack_clear", bus.d_ack, 1'b0);

        // Reset during BUSY_I, then a late m_ready.
        bus.if_req = 1'b1; bus.if_addr = 32'h0000_0500;
        tick();
        chk1("rbi_m_req", bus.m_req, 1'b1);
        RST = 1'b1;
        tick();
        chk1("rbi_m_req_drop", bus.m_req, 1'b0);
        chk1("rbi_state", dut.state_r == IDLE, 1'b1);
        chk1("rbi_if_ack", bus.if_ack, 1'b0);
        chk32("rbi_starve", {29'd0, dut.u_starve.cnt_r}, 32'd0);
        RST = 1'b0; bus.if_req = 1'b0;
        bus.m_ready = 1'b1; bus.m_rdata = 32'h7777_7777;
        tick();
        bus.m_ready = 1'b0;
        chk1("rbi_late_ack", bus.if_ack | bus.d_ack, 1'b0);
        chk1("rbi_late_m_req", bus.m_req, 1'b0);
        tick();
        chk1("rbi_late_ack2", bus.if_ack | bus.d_ack, 1'b0);

        // Reset during BUSY_D with fetch waiting clears a nonzero counter.
        bus.if_req = 1'b1; bus.if_addr = 32'h0000_0600;
        bus.d_req = 1'b1; bus.d_we = 1'b0; bus.d_addr = 32'h0000_0700;
        tick();
        chk1("rbd_m_req", bus.m_req, 1'b1);
        chk32("rbd_m_addr", bus.m_addr, 32'h0000_0700);
        chk32("rbd_starve_one", {29'd0, dut.u_starve.cnt_r}, 32'd1);
        RST = 1'b1;
        tick();
        chk1("rbd_m_req_drop", bus.m_req, 1'b0);
        chk32("rbd_starve", {29'd0, dut.u_starve.cnt_r}, 32'd0);
        chk1("rbd_d_ack", bus.d_ack, 1'b0);
        bus.if_req = 1'b0; bus.d_req = 1'b0;
        tick();
        RST = 1'b0;
        tick();

        rand_phase(1500);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares one single-ported memory/IO bus between the fetch stage (instruction reads) and the memory stage (data loads/stores) of the 5-stage OTTER pipeline.
- Sits between the pipeline and Memory/IOBUS and holds one transaction in flight at a time.
- Returns per-requester acks and stall outputs; the hazard logic ORs these stalls into its freeze of PC and pipeline registers.
- Data has priority over fetch, with a starvation guard so fetch cannot be locked out.

Parameters:
STARVE_MAX, 4, consecutive data grants allowed while if_req waits before fetch is forced to win (1..2^CNT_W-1)
CNT_W, 3, width of the starvation counter

Ports:
CLK  in  1  clock
RST  in  1  reset, synchronous, active-high
if_req  in  1  fetch request, level, held until if_ack
if_addr  in  32  fetch byte address (word-aligned)
if_ack  out  1  one-cycle pulse, if_rdata valid
if_rdata  out  32  fetched instruction
d_req  in  1  data request, level, held until d_ack
d_we  in  1  1=store, 0=load
d_addr  in  32  data byte address
d_wdata  in  32  store data
d_size  in  2  0=byte, 1=half, 2=word
d_sign  in  1  0=sign-extend load, 1=zero-extend (funct3[2])
d_ack  out  1  one-cycle pulse, load data valid / store done
d_rdata  out  32  load data
m_req  out  1  memory request, held until m_ready
m_we  out  1  memory write enable
m_addr  out  32  memory address
m_wdata  out  32  memory write data
m_size  out  2  memory access size
m_sign  out  1  memory sign control
m_ready  in  1  memory completion pulse; m_rdata valid same cycle
m_rdata  in  32  memory read data
stall_if  out  1  if_req & ~if_ack
stall_mem  out  1  d_req & ~d_ack

Behaviour:
- States: IDLE, BUSY_I, BUSY_D, RESP.
- All transitions on posedge CLK. RST has priority over everything.
- Reset values: state=IDLE, all m_* = 0, if_ack=d_ack=0, if_rdata=d_rdata=0, starve_cnt=0.
- IDLE arbitration:
  - d_req only -> BUSY_D.
  - if_req only -> BUSY_I.
  - both -> BUSY_D, unless starve_cnt==STARVE_MAX, then BUSY_I.
  - Neither -> stay in IDLE.
- Grant capture: on the grant edge, address/we/wdata/size/sign are captured into registers that drive m_*. Requester changes after the grant are ignored until the ack.
  - Fetch grant: m_we=0, m_size=2, m_sign=0.
- BUSY_x: m_req=1 with stable m_* until m_ready. On m_ready, latch m_rdata into the granted port's rdata register and go to RESP.
  - m_ready in IDLE/RESP is ignored.
  - There is no timeout; a missing m_ready stalls indefinitely.
- RESP (one cycle): m_req=0, granted port's ack=1, then IDLE. The requester drops or changes req in the ack cycle, so it is not re-granted stale.
- Store: d_rdata is loaded with 0. No internal extension is applied (Memory applies size/sign).
- Latency: request visible in IDLE at cycle 0 -> m_req cycle 1 -> zero-wait m_ready cycle 1 -> ack cycle 2. One transaction per 3 cycles minimum.
- starve_cnt:
  - +1 (saturating at STARVE_MAX) on each data grant made while if_req=1.
  - Cleared on every fetch grant, and on a data grant with if_req=0.
- Requester deasserts req before grant: allowed only while in IDLE. Once granted, the transaction completes and the ack is still pulsed.
- Reset mid-BUSY: m_req drops the next cycle, the transaction is abandoned, and no ack is issued. The memory must treat a dropped m_req as cancel.
- stall_if / stall_mem are combinational from req and ack. They are 0 during reset only if the reqs are 0.

Decomposition:
- Shared package otter_pkg: arb_state_t enum {IDLE, BUSY_I, BUSY_D, RESP}, and MEM_SIZE_BYTE/HALF/WORD constants (0/1/2).
- Natural sub-module: starve_counter. This is a saturating counter with inc/clr/sat output, parameterised by CNT_W and STARVE_MAX.
- The FSM and capture registers stay in mem_port_arbiter.

Test Plan:
- Fetch only, zero-wait memory: if_req=1, if_addr=0x100, m_ready returns 0x00500093 in cycle 1 -> m_req cycle 1 with m_addr=0x100, m_size=2; if_ack and if_rdata=0x00500093 in cycle 2; stall_if=1 in cycles 0-1.
- Simultaneous requests: if_req and d_req with d_we=1, d_addr=0x1004, d_wdata=0xDEADBEEF, d_size=2 -> data served first (m_we=1, m_wdata=0xDEADBEEF, d_rdata=0); fetch granted in the next IDLE.
- Starvation: if_req held, d_req re-asserted immediately after each ack, STARVE_MAX=4 -> exactly 4 data acks, then 1 fetch ack, then data resumes.
- Wait states: m_ready delayed 5 cycles and d_addr changed during BUSY_D -> m_addr stays at the granted value; d_ack arrives 1 cycle after m_ready; stall_mem high throughout.
- Reset mid-operation: RST during BUSY_I -> next cycle m_req=0, state IDLE, no if_ack, starve_cnt=0; a late m_ready is ignored.
- Load byte: d_size=0, d_sign=0, d_addr=0x2003, m_rdata=0xFFFFFF80 -> m_size=0, m_sign=0; d_rdata=0xFFFFFF80 passed unchanged.
